iomem_fb_write_bridge: RTL and testbench



---
 rtl/iomem_fb_write_bridge.sv | 160 ++++++++++++++++
 tb/tb_iomem_fb_write_bridge.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_fb_write_bridge.sv
// ---------------------------------------------------------------------------
// iomem_fb_write_bridge
//
// Responder on the picosoc iomem bus for the BASE_SEL address window.
// CPU stores are queued in a small FIFO and drained to the framebuffer
// write port with a valid/ready handshake. Display-side back-pressure
// stalls the CPU only when the FIFO is full. Every accepted access gets
// exactly one registered iomem_ready pulse, so an access takes at least
// two cycles.
//
// Optional build macro:
//   IOMEM_FB_STATUS_EN  reads return {16'h0, count[7:0], 6'b0, full, empty}.
//                       Without it, reads return 32'h0 with the same timing.
//
// Ports:
//   clk, resetn    system clock, asynchronous active-low reset
//   iomem_valid    bus request valid
//   iomem_ready    one-cycle completion pulse (registered)
//   iomem_wstrb    byte strobes, 4'b0000 means read
//   iomem_addr     byte address; [31:24] selects, [FB_AW+1:2] is the word
//   iomem_wdata    store data
//   iomem_rdata    read data, valid while iomem_ready=1, otherwise 0
//   fb_valid       FIFO head presented to the framebuffer
//   fb_ready       framebuffer accepts the head this cycle
//   fb_addr        framebuffer word address of the head entry
//   fb_wdata       data of the head entry
//   fb_wstrb       byte strobes of the head entry (never 0)
// ---------------------------------------------------------------------------
module iomem_fb_write_bridge #(
    parameter logic [7:0] BASE_SEL   = 8'h04,
    parameter int         FB_AW      = 13,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    output logic             fb_valid,
    input  logic             fb_ready,
    output logic [FB_AW-1:0] fb_addr,
    output logic [31:0]      fb_wdata,
    output logic [3:0]       fb_wstrb
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t           state;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic [FB_AW-1:0] mem_addr  [FIFO_DEPTH];
    logic [31:0]      mem_wdata [FIFO_DEPTH];
    logic [3:0]       mem_wstrb [FIFO_DEPTH];

    logic             sel;
    logic             is_write;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [31:0]      read_value;

    // Address bits that take no part in decode or the word address.
    logic             addr_unused;
    assign addr_unused = ^{iomem_addr[23:FB_AW+2], iomem_addr[1:0]};

    // The !iomem_ready term keeps the still-asserted request of the
    // response cycle from being taken as a second access.
    assign sel      = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_SEL);
    assign is_write = |iomem_wstrb;
    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);

    // Fullness is judged on the current count, so a pop on the same edge
    // does not make room; the write is taken on the following cycle.
    assign push = (state == IDLE) && sel && is_write && !full;
    assign pop  = !empty && fb_ready;

`ifdef IOMEM_FB_STATUS_EN
    assign read_value = {16'h0, 8'(count), 6'b0, full, empty};
`else
    assign read_value = 32'h0000_0000;
`endif

    // Bus-side FSM; iomem_ready and iomem_rdata are registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'h0;
        end else if (state == IDLE) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'h0;
            if (sel) begin
                if (!is_write) begin
                    iomem_rdata <= read_value;
                    iomem_ready <= 1'b1;
                    state       <= RESP;
                end else if (!full) begin
                    iomem_ready <= 1'b1;
                    state       <= RESP;
                end
            end
        end else begin
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'h0;
            state       <= IDLE;
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because the
    // depth is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // FIFO storage carries data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr]  <= iomem_addr[FB_AW+1:2];
            mem_wdata[wr_ptr] <= iomem_wdata;
            mem_wstrb[wr_ptr] <= iomem_wstrb;
        end
    end

    // Head fields are forced to zero while empty so stale or uninitialised
    // storage never shows on the framebuffer port.
    assign fb_valid = !empty;
    assign fb_addr  = empty ? '0    : mem_addr[rd_ptr];
    assign fb_wdata = empty ? 32'h0 : mem_wdata[rd_ptr];
    assign fb_wstrb = empty ? 4'h0  : mem_wstrb[rd_ptr];

endmodule

// File: tb/tb_iomem_fb_write_bridge.sv
module tb_iomem_fb_write_bridge;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = 32'h0;
    logic [31:0] iomem_wdata = 32'h0;
    logic [31:0] iomem_rdata;
    logic        fb_valid;
    logic        fb_ready = 1'b0;
    logic [12:0] fb_addr;
    logic [31:0] fb_wdata;
    logic [3:0]  fb_wstrb;

    int vectors = 0;
    int miscompares = 0;

    iomem_fb_write_bridge #(
        .BASE_SEL  (8'h04),
        .FB_AW     (13),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr (iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata),
        .fb_valid   (fb_valid),
        .fb_ready   (fb_ready),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .fb_wstrb   (fb_wstrb)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Status word as a read should return it with n entries queued.
    function automatic logic [31:0] exp_status(input int n);
`ifdef IOMEM_FB_STATUS_EN
        return {16'h0, 8'(n), 6'b0, (n == DEPTH), (n == 0)};
`else
        return 32'h0;
`endif
    endfunction

    // One bus access; returns whether ready was seen within the budget.
    task automatic bus_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input int budget, output logic got, output logic [31:0] rd);
        int cyc;
        iomem_addr  = a;
        iomem_wdata = d;
        iomem_wstrb = s;
        iomem_valid = 1'b1;
        got = 1'b0;
        rd  = 32'h0;
        cyc = 0;
        while (!got && cyc < budget) begin
            tick();
            cyc++;
            if (iomem_ready) begin
                got = 1'b1;
                rd  = iomem_rdata;
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    // ---------------- reference model for the random phase ----------------
    typedef struct {
        logic [12:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } beat_t;

    beat_t mq[$];
    logic  mon_en = 1'b0;
    logic  rand_fb = 1'b0;
    logic  hold_fb = 1'b0;

    // A beat happens at the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (mon_en && resetn && fb_valid && fb_ready) begin
            if (mq.size() == 0) begin
                check("beat_unexpected", {19'h0, fb_addr}, 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                e = mq.pop_front();
                check("beat_addr", {19'h0, fb_addr}, {19'h0, e.a});
                check("beat_data", fb_wdata, e.d);
                check("beat_strb", {28'h0, fb_wstrb}, {28'h0, e.s});
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_fb) fb_ready = hold_fb ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        resp;
        logic        push;
        logic [12:0] fa;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[8];

    logic        got;
    logic [31:0] rd;
    logic [12:0] b_addr [8];
    logic [31:0] b_data [8];
    int          nb;
    int          bad;
    logic        got5;

    initial begin
        tbl[0] = '{32'h0400_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 13'd4,      32'h0};
        tbl[1] = '{32'h0400_0004, 32'h1234_5678, 4'h2, 1'b1, 1'b1, 13'd1,      32'h0};
        tbl[2] = '{32'h0300_0000, 32'hAAAA_5555, 4'hF, 1'b0, 1'b0, 13'd0,      32'h0};
        tbl[3] = '{32'h0400_7FFC, 32'h0BAD_F00D, 4'h8, 1'b1, 1'b1, 13'h1FFF,   32'h0};
        tbl[4] = '{32'h0408_0003, 32'hCAFE_0001, 4'h1, 1'b1, 1'b1, 13'd0,      32'h0};
        tbl[5] = '{32'h0500_0010, 32'h5555_AAAA, 4'hF, 1'b0, 1'b0, 13'd0,      32'h0};
        tbl[6] = '{32'h0400_0100, 32'h0,         4'h0, 1'b1, 1'b0, 13'd0,      exp_status(0)};
        tbl[7] = '{32'h0300_0000, 32'h0,         4'h0, 1'b0, 1'b0, 13'd0,      32'h0};

        // Reset state
        #12;
        check("rst_ready", {31'h0, iomem_ready}, 32'h0);
        check("rst_rdata", iomem_rdata, 32'h0);
        check("rst_fb_valid", {31'h0, fb_valid}, 32'h0);
        check("rst_fb_head", {fb_wstrb, 15'h0, fb_addr} ^ fb_wdata, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (10) tick();
        check("idle_fb_valid", {31'h0, fb_valid}, 32'h0);

        // Table of single accesses on an empty FIFO
        for (int i = 0; i < 8; i++) begin
            fb_ready = 1'b0;
            bus_access(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, 6, got, rd);
            check($sformatf("tbl%0d_resp", i), {31'h0, got}, {31'h0, tbl[i].resp});
            check($sformatf("tbl%0d_fb_valid", i), {31'h0, fb_valid}, {31'h0, tbl[i].push});
            if (tbl[i].push) begin
                check($sformatf("tbl%0d_fb_addr", i), {19'h0, fb_addr}, {19'h0, tbl[i].fa});
                check($sformatf("tbl%0d_fb_wdata", i), fb_wdata, tbl[i].wdata);
                check($sformatf("tbl%0d_fb_wstrb", i), {28'h0, fb_wstrb}, {28'h0, tbl[i].wstrb});
            end
            if (tbl[i].resp && !tbl[i].push) begin
                check($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
            end
            fb_ready = 1'b1;
            tick();
            fb_ready = 1'b0;
            check($sformatf("tbl%0d_drained", i), {31'h0, fb_valid}, 32'h0);
            check($sformatf("tbl%0d_ready_off", i), {31'h0, iomem_ready}, 32'h0);
        end

        // Single write with fb_ready high: one pulse, one beat
        fb_ready = 1'b1;
        bus_access(32'h0400_0010, 32'hDEAD_BEEF, 4'hF, 6, got, rd);
        check("single_resp", {31'h0, got}, 32'h1);
        check("single_fb", {fb_valid, 18'h0, fb_addr}, {1'b1, 18'h0, 13'd4});
        check("single_wdata", fb_wdata, 32'hDEAD_BEEF);
        tick();
        check("single_pulse_1cyc", {31'h0, iomem_ready}, 32'h0);
        check("single_one_beat", {31'h0, fb_valid}, 32'h0);
        fb_ready = 1'b0;

        // Five writes into a four-deep FIFO with the framebuffer stalled
        for (int i = 0; i < 4; i++) begin
            bus_access(32'h0400_0000 + 32'(4 * i), 32'h1000 + 32'(i), 4'hF, 4, got, rd);
            check($sformatf("fill%0d_resp", i), {31'h0, got}, 32'h1);
        end
        iomem_addr  = 32'h0400_0010;
        iomem_wdata = 32'h1004;
        iomem_wstrb = 4'hF;
        iomem_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (iomem_ready) bad++;
        end
        check("full_stall", 32'(bad), 32'h0);
        fb_ready = 1'b1;
        nb = 0;
        got5 = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (fb_valid && nb < 8) begin
                b_addr[nb] = fb_addr;
                b_data[nb] = fb_wdata;
                nb++;
            end
            tick();
            if (iomem_ready && iomem_valid) begin
                got5 = 1'b1;
                iomem_valid = 1'b0;
                iomem_wstrb = 4'h0;
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        fb_ready = 1'b0;
        check("fifth_resp", {31'h0, got5}, 32'h1);
        check("beat_count", 32'(nb), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("order%0d_addr", i), {19'h0, b_addr[i]}, 32'(i));
            check($sformatf("order%0d_data", i), b_data[i], 32'h1000 + 32'(i));
        end

        // Status read with two entries queued
        bus_access(32'h0400_0020, 32'hA0, 4'hF, 4, got, rd);
        bus_access(32'h0400_0024, 32'hA1, 4'hF, 4, got, rd);
        bus_access(32'h0400_0000, 32'h0, 4'h0, 4, got, rd);
        check("status_resp", {31'h0, got}, 32'h1);
`ifdef IOMEM_FB_STATUS_EN
        check("status_rdata", rd, 32'h0000_0200);
`else
        check("status_rdata", rd, 32'h0000_0000);
`endif
        tick();
        check("rdata_idle_zero", iomem_rdata, 32'h0);

        // Asynchronous reset with three entries queued
        bus_access(32'h0400_0028, 32'hA2, 4'hF, 4, got, rd);
        check("pre_rst_head", fb_wdata, 32'hA0);
        #3;
        resetn = 1'b0;
        #1;
        check("async_rst_fb_valid", {31'h0, fb_valid}, 32'h0);
        check("async_rst_ready", {31'h0, iomem_ready}, 32'h0);
        tick();
        resetn = 1'b1;
        fb_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            if (fb_valid) bad++;
            tick();
        end
        check("post_rst_no_beats", 32'(bad), 32'h0);
        fb_ready = 1'b0;

        // Randomised traffic against the queue model
        mq.delete();
        mon_en  = 1'b1;
        rand_fb = 1'b1;
        for (int n = 0; n < 200; n++) begin
            int          kind;
            logic [31:0] a;
            logic [31:0] d;
            logic [3:0]  s;
            kind = int'($urandom_range(0, 9));
            a = {8'h04, 24'($urandom)};
            d = $urandom;
            if (kind == 0) begin
                a[31:24] = ($urandom_range(0, 1) == 0) ? 8'h03 : 8'h05;
                bus_access(a, d, 4'($urandom_range(0, 15)), 6, got, rd);
                check("rnd_foreign_resp", {31'h0, got}, 32'h0);
            end else if (kind <= 2) begin
                hold_fb = 1'b1;
                tick();
                tick();
                bus_access(a, d, 4'h0, 6, got, rd);
                check("rnd_read_resp", {31'h0, got}, 32'h1);
                check("rnd_read_rdata", rd, exp_status(mq.size()));
                hold_fb = 1'b0;
            end else begin
                s = 4'($urandom_range(1, 15));
                bus_access(a, d, s, 40, got, rd);
                check("rnd_write_resp", {31'h0, got}, 32'h1);
                if (got) mq.push_back('{a[14:2], d, s});
            end
        end
        rand_fb = 1'b0;
        fb_ready = 1'b1;
        for (int c = 0; c < 20 && mq.size() != 0; c++) tick();
        tick();
        check("rnd_drained", 32'(mq.size()), 32'h0);
        check("rnd_empty", {31'h0, fb_valid}, 32'h0);
        mon_en = 1'b0;
        fb_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
